angle_hist_buf: RTL

//  Parametrised circular history buffer for angle samples, the next generation of the single-port angle buffer.
//  - Stores the last DEPTH samples from the angle stage.
//  - Serves NUM_RD independent lag lookups, each a registered read, replacing whole-array exposure.
//  - Tracks fill level and supports a per-frame restart; feeds select_eps and later correlation stages.

---
 rtl/angle_hist_buf.sv | 70 +++++++
 1 files changed

// File: rtl/angle_hist_buf.sv
// angle_hist_buf: circular history of angle samples with NUM_RD registered lag lookups
module angle_hist_buf #(
  parameter int DATA_W = 13,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int NUM_RD = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         frame_start,
  input  logic                         in_valid,
  input  logic [DATA_W-1:0]            in_data,
  output logic                         buf_valid,
  output logic [ADDR_W-1:0]            wr_ptr,
  output logic [ADDR_W:0]              fill_cnt,
  output logic                         full,
  input  logic [NUM_RD-1:0]            rd_req,
  input  logic [NUM_RD*(ADDR_W+1)-1:0] rd_lag,
  output logic [NUM_RD-1:0]            rd_valid,
  output logic [NUM_RD-1:0]            rd_hit,
  output logic [NUM_RD*DATA_W-1:0]     rd_data
);
  localparam int LW = ADDR_W + 1;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] ptr_base;
  logic [ADDR_W:0]   cnt_base;
  logic [ADDR_W:0]   lag  [NUM_RD];
  logic [ADDR_W-1:0] addr [NUM_RD];
  logic [NUM_RD-1:0] hit;
  // A frame restart rebases pointer and count before the same-cycle write is applied
  assign ptr_base = frame_start ? '0 : wr_ptr;
  assign cnt_base = frame_start ? '0 : fill_cnt;
  assign full     = fill_cnt == LW'(DEPTH);
  // Lookups use start-of-cycle pointer and count so a same-edge write stays invisible
  always_comb begin
    for (int k = 0; k < NUM_RD; k++) begin
      lag[k]  = rd_lag[k*LW +: LW];
      addr[k] = wr_ptr - lag[k][ADDR_W-1:0];
      hit[k]  = rd_req[k] && lag[k] != '0 && lag[k] <= fill_cnt;
    end
  end
  // Pointer and saturating fill count; both hold when no sample arrives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      fill_cnt  <= '0;
      buf_valid <= 1'b0;
    end else begin
      wr_ptr    <= in_valid ? ptr_base + ADDR_W'(1) : ptr_base;
      fill_cnt  <= in_valid && cnt_base != LW'(DEPTH) ? cnt_base + LW'(1) : cnt_base;
      buf_valid <= in_valid;
    end
  end
  // Sample storage is deliberately left unreset
  always_ff @(posedge clk) begin
    if (in_valid) mem[ptr_base] <= in_data;
  end
  // Registered read ports; misses return zero rather than stale data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= '0;
      rd_hit   <= '0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_req;
      rd_hit   <= hit;
      for (int k = 0; k < NUM_RD; k++) rd_data[k*DATA_W +: DATA_W] <= hit[k] ? mem[addr[k]] : '0;
    end
  end
endmodule
